// File: rtl/wb_latency_ram.sv
// wb_latency_ram: pipelined Wishbone word RAM with fixed response latency, bounded
// outstanding requests and optional periodic stall injection.
module wb_latency_ram #(
  parameter int AWIDTH       = 15,
  parameter int LATENCY      = 2,
  parameter int DEPTH        = 4,
  parameter int STALL_PERIOD = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cyc_i,
  input  logic              stb_i,
  input  logic              we_i,
  input  logic [3:0]        sel_i,
  input  logic [AWIDTH-1:0] adr_i,
  input  logic [31:0]       dat_i,
  output logic [31:0]       dat_o,
  output logic              ack_o,
  output logic              stall_o
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = STALL_PERIOD > 1 ? $clog2(STALL_PERIOD) : 1;

  logic [31:0]              mem_q [2**AWIDTH];
  logic [LATENCY-1:0]       vld_q, vld_d, we_q, we_d;
  logic [LATENCY-1:0][31:0] dat_q, dat_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [PW-1:0]            inj_q, inj_d;
  logic                     inject, accept;

  always_comb begin
    inject  = STALL_PERIOD > 1 && inj_q == PW'(STALL_PERIOD - 1);
    stall_o = (cnt_q == CW'(DEPTH)) | inject;
    accept  = cyc_i & stb_i & ~stall_o;
    ack_o   = vld_q[LATENCY-1] & cyc_i;
    dat_o   = ack_o & ~we_q[LATENCY-1] ? dat_q[LATENCY-1] : '0;
    // Dropping cyc_i flushes every in-flight response so none can leak into the next cycle.
    vld_d   = cyc_i ? (vld_q << 1) | LATENCY'(accept) : '0;
    we_d    = (we_q << 1) | LATENCY'(we_i);
    dat_d   = dat_q << 32;
    dat_d[0] = mem_q[adr_i];
    cnt_d   = cyc_i ? cnt_q + CW'(accept) - CW'(ack_o) : '0;
    inj_d   = STALL_PERIOD < 2 || inject ? '0 : inj_q + PW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q <= '0;
      we_q  <= '0;
      dat_q <= '0;
      cnt_q <= '0;
      inj_q <= '0;
    end else begin
      vld_q <= vld_d;
      we_q  <= we_d;
      dat_q <= dat_d;
      cnt_q <= cnt_d;
      inj_q <= inj_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept & we_i)
      for (int b = 0; b < 4; b++)
        if (sel_i[b]) mem_q[adr_i][8*b +: 8] <= dat_i[8*b +: 8];
  end
endmodule

// File: tb/tb_wb_latency_ram.sv
// tb_wb_latency_ram: two responder configurations on shared stimulus, checked each cycle
// against a time-slot schedule model of expected stalls, acks and read data.
module tb_wb_latency_ram;
  localparam int AW = 15;
  logic clk_i = 1'b0;
  logic rst_i, cyc_i, stb_i, we_i;
  logic [3:0] sel_i;
  logic [AW-1:0] adr_i;
  logic [31:0] dat_i;
  logic [1:0][31:0] dat_w;
  logic [1:0] ack_w, stall_w;

  always #5 clk_i = ~clk_i;

  wb_latency_ram #(.AWIDTH(AW), .LATENCY(2), .DEPTH(4), .STALL_PERIOD(0)) u0 (
    .clk_i(clk_i), .rst_i(rst_i), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i),
    .sel_i(sel_i), .adr_i(adr_i), .dat_i(dat_i),
    .dat_o(dat_w[0]), .ack_o(ack_w[0]), .stall_o(stall_w[0]));

  wb_latency_ram #(.AWIDTH(AW), .LATENCY(3), .DEPTH(2), .STALL_PERIOD(4)) u1 (
    .clk_i(clk_i), .rst_i(rst_i), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i),
    .sel_i(sel_i), .adr_i(adr_i), .dat_i(dat_i),
    .dat_o(dat_w[1]), .ack_o(ack_w[1]), .stall_o(stall_w[1]));

  int checks = 0, errors = 0;
  int lat[2] = '{2, 3};
  int dep[2] = '{4, 2};
  int per[2] = '{0, 4};
  logic [31:0] ref_mem[2][16];
  bit sv[2][16], swe[2][16];
  logic [31:0] sdat[2][16];
  int n_out[2];
  int cur;
  bit acc_last[2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      n_out[i] = 0;
      for (int s = 0; s < 16; s++) sv[i][s] = 0;
    end
    cur = 0;
  endtask

  // Slot t holds the response due in the cycle after clock edge t.
  task automatic eval();
    for (int i = 0; i < 2; i++) begin
      int s = cur % 16;
      bit inj = per[i] > 1 && cur % per[i] == per[i] - 1;
      bit st = n_out[i] == dep[i] || inj;
      bit ak = sv[i][s] && cyc_i;
      bit acc = cyc_i && stb_i && !st;
      logic [3:0] a = adr_i[3:0];
      logic [31:0] ed = ak && !swe[i][s] ? sdat[i][s] : 32'h0;
      chk($sformatf("stall%0d@%0d", i, cur), 32'(stall_w[i]), 32'(st));
      chk($sformatf("ack%0d@%0d", i, cur), 32'(ack_w[i]), 32'(ak));
      chk($sformatf("dat%0d@%0d", i, cur), dat_w[i], ed);
      sv[i][s] = 0;
      if (acc) begin
        if (we_i)
          for (int b = 0; b < 4; b++)
            if (sel_i[b]) ref_mem[i][a][8*b +: 8] = dat_i[8*b +: 8];
        sv[i][(cur + lat[i]) % 16] = 1;
        swe[i][(cur + lat[i]) % 16] = we_i;
        sdat[i][(cur + lat[i]) % 16] = ref_mem[i][a];
      end
      if (!cyc_i) begin
        for (int k = 0; k < 16; k++) sv[i][k] = 0;
        n_out[i] = 0;
      end else n_out[i] += int'(acc) - int'(ak);
      acc_last[i] = acc;
    end
    cur++;
  endtask

  task automatic cyc_step(input bit c, input bit s, input bit w, input logic [3:0] sl,
                          input logic [3:0] a, input logic [31:0] d);
    cyc_i = c; stb_i = s; we_i = w; sel_i = sl; adr_i = AW'(a); dat_i = d;
    @(negedge clk_i);
    eval();
    @(posedge clk_i);
    #1;
  endtask

  // Holds a request until both responders have taken it.
  task automatic req(input bit w, input logic [3:0] sl, input logic [3:0] a, input logic [31:0] d);
    bit done0 = 0, done1 = 0;
    for (int n = 0; n < 20 && !(done0 && done1); n++) begin
      cyc_step(1, 1, w, sl, a, d);
      done0 |= acc_last[0];
      done1 |= acc_last[1];
    end
    chk("req_accepted", 32'(done0 && done1), 32'd1);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc_step(1, 0, 0, 4'h0, 4'h0, 32'h0);
  endtask

  initial begin
    rst_i = 1; cyc_i = 0; stb_i = 0; we_i = 0; sel_i = 0; adr_i = 0; dat_i = 0;
    @(posedge clk_i);
    #1;
    chk("rst_ack0", 32'(ack_w[0]), 32'd0);
    chk("rst_stall1", 32'(stall_w[1]), 32'd0);
    chk("rst_dat0", dat_w[0], 32'h0);
    rst_i = 0;
    model_reset();
    for (int a = 0; a < 16; a++) req(1, 4'hF, 4'(a), $urandom);
    idle(4);
    req(1, 4'hF, 4'd5, 32'hDEADBEEF);
    req(0, 4'hF, 4'd5, 32'h0);
    idle(4);
    req(1, 4'hF, 4'd9, 32'h11223344);
    req(1, 4'b0010, 4'd9, 32'h0000AB00);
    req(0, 4'hF, 4'd9, 32'h0);
    req(0, 4'h0, 4'd9, 32'h0);
    idle(5);
    for (int a = 0; a < 4; a++) req(0, 4'hF, 4'(a), 32'h0);
    idle(6);
    cyc_step(1, 1, 0, 4'hF, 4'd1, 32'h0);
    cyc_step(1, 1, 0, 4'hF, 4'd2, 32'h0);
    cyc_step(0, 0, 0, 4'h0, 4'd0, 32'h0);
    req(0, 4'hF, 4'd3, 32'h0);
    idle(5);
    for (int k = 0; k < 40; k++) cyc_step(1, 1, 0, 4'hF, 4'($urandom_range(0, 15)), 32'h0);
    idle(5);
    for (int k = 0; k < 3; k++) cyc_step(1, 1, 0, 4'hF, 4'($urandom_range(0, 15)), 32'h0);
    rst_i = 1;
    #2;
    chk("midrst_ack0", 32'(ack_w[0]), 32'd0);
    chk("midrst_ack1", 32'(ack_w[1]), 32'd0);
    chk("midrst_stall0", 32'(stall_w[0]), 32'd0);
    chk("midrst_stall1", 32'(stall_w[1]), 32'd0);
    chk("midrst_dat0", dat_w[0], 32'h0);
    #1;
    rst_i = 0;
    model_reset();
    idle(4);
    req(0, 4'hF, 4'd5, 32'h0);
    req(0, 4'hF, 4'd9, 32'h0);
    idle(4);
    for (int k = 0; k < 300; k++)
      cyc_step($urandom_range(0, 15) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
               4'($urandom), 4'($urandom), $urandom);
    idle(6);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
